bias_seq_ctrl: RTL and testbench
================================

Name: bias_seq_ctrl

Overview:
Sequencer that drives one bias ROM (1-cycle read latency, clock-enabled) and streams bias coefficients into a layer's downstream FIFO in the order the accumulator consumes them. Once started, it emits channel 0..NUM_CH-1 biases, repeated once per output pixel for NUM_PIX pixels, then signals done. It sits between the per-layer bias ROM and the conv accumulator's bias input FIFO, and it absorbs FIFO backpressure without losing in-flight ROM reads.

Parameters:
- COEFF_W, 16, bias word width (matches shared coeff width).
- NUM_CH, 32, number of output channels (ROM depth); must be ≥1.
- NUM_PIX, 64, number of output pixels per frame; must be ≥1.
- ADDR_W, $clog2(NUM_CH) (min 1), ROM address width.

Ports:
- ap_clk  in  1  clock, all logic on the rising edge.
- ap_rst  in  1  reset, asynchronous, active-high.
- ap_start  in  1  start a frame; sampled only in IDLE.
- ap_idle  out  1  high in IDLE.
- ap_done  out  1  one-cycle pulse after the last word is accepted.
- bias_V_address0  out  ADDR_W  ROM address.
- bias_V_ce0  out  1  ROM read enable; q is valid the cycle after ce is high.
- bias_V_q0  in  COEFF_W  ROM data.
- output_V_din  out  COEFF_W  bias word to FIFO.
- output_V_full_n  in  1  FIFO not-full.
- output_V_write  out  1  write strobe; transfer occurs when write=1 and full_n=1.

Behaviour:
- Reset (async assert): state=IDLE; ap_idle=1; ap_done=0; bias_V_ce0=0; bias_V_address0=0; output_V_write=0; output_V_din=0; all counters, credit and skid entries cleared. Any in-flight ROM read is discarded.
- FSM: IDLE -> RUN on ap_start=1.
  - RUN -> DRAIN when the last read (ch=NUM_CH-1, pix=NUM_PIX-1) has been issued.
  - DRAIN -> DONE when the buffer is empty and no read is in flight.
  - DONE -> IDLE unconditionally; ap_done=1 only in DONE.
  - ap_start is ignored outside IDLE.
- Read issue: 2-entry output buffer (head + skid). Define occupancy = buffered entries + reads in flight (0..2). In RUN, ce0=1 when occupancy<2, or when occupancy==2 and a transfer occurs this cycle. The address is the current ch counter.
- Counters on each issued read: ch increments and wraps NUM_CH-1 -> 0; on that wrap, pix increments. No reads are issued in IDLE, DRAIN or DONE.
- Data capture: the cycle after ce0=1, q0 is written to the head if the head is empty (or is emptying this cycle), else to the skid. Order is strictly preserved.
- Output: output_V_write = head_valid (registered valid; asserted independent of full_n); output_V_din = head data.
  - On transfer, skid moves to head, else head is cleared.
  - With full_n held high and steady state, throughput is 1 word/cycle. First word appears on din 2 cycles after the ap_start sample.
- Backpressure: full_n=0 holds din/write stable; at most 2 words are buffered, so no read is ever lost.
- Total words per frame = NUM_CH*NUM_PIX exactly.
- NUM_CH=1: address is constant 0, ch wraps every read.
- Simultaneous capture and transfer in the same cycle is legal and must not drop or duplicate a word.

Optional Feature:
- Macro: BIAS_SEQ_STALL_CNT_EN.
- Defined: adds output port stall_cnt (32-bit).
  - Increments each cycle write=1 and full_n=0.
  - Clears on reset and on the IDLE->RUN transition.
  - Saturates at all-ones.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package/header: COEFF_W default, FSM state encoding (IDLE/RUN/DRAIN/DONE), per-layer NUM_CH/NUM_PIX constants.
- One natural sub-module, bias_skid_buf: the 2-entry order-preserving buffer with occupancy/credit output, reusable for other ROM-fed streamers.

Test Plan:
- NUM_CH=4, NUM_PIX=3, ROM={10,20,30,40}, full_n=1 -> 12 writes on consecutive cycles: 10,20,30,40 ×3; ap_done pulses once, 1 cycle after the 12th transfer; ap_idle returns to 1.
- Same config, full_n toggling 1,0,0,1 repeatedly -> identical 12-word sequence, no duplicates or drops; ce0 never raised with occupancy==2 and no transfer.
- full_n=0 from cycle 3 for 20 cycles -> din/write frozen, at most 2 reads beyond accepted words; on release, sequence resumes in order.
- ap_rst asserted mid-frame after 5 words -> outputs immediately at reset values; after a new ap_start, the sequence restarts at 10.
- ap_start held high during RUN and re-pulsed in DONE -> ignored until IDLE; a second frame then produces the same 12 words.
- NUM_CH=1, NUM_PIX=5, ROM={7}; with BIAS_SEQ_STALL_CNT_EN and 3 stall cycles -> five 7s, stall_cnt=3.

Source files
------------

// File: rtl/bias_seq_ctrl_pkg.sv
// Shared definitions for the bias sequencer: default sizes, FSM encoding and helpers.
// Optional stall counter is enabled by defining BIAS_SEQ_STALL_CNT_EN.
package bias_seq_ctrl_pkg;

  localparam int COEFF_W_DEF = 16;
  localparam int NUM_CH_DEF  = 32;
  localparam int NUM_PIX_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // Counter/address width for a given depth, never below one bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] val);
    return (val == 32'hFFFF_FFFF) ? val : (val + 32'd1);
  endfunction

endpackage

// File: rtl/bias_seq_ctrl_skid_buf.sv
// bias_skid_buf: order-preserving head+skid buffer for a 1-cycle-latency ROM source.
// Tracks the in-flight read so occupancy/credit covers everything not yet delivered.
module bias_skid_buf #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_fire,
  output logic [1:0]        occupancy,
  output logic              can_issue
);

  logic              pend_r;
  logic              head_v_r;
  logic [DATA_W-1:0] head_d_r;
  logic              skid_v_r;
  logic [DATA_W-1:0] skid_d_r;

  logic              head_v_n;
  logic [DATA_W-1:0] head_d_n;
  logic              skid_v_n;
  logic [DATA_W-1:0] skid_d_n;
  logic              fire_s;

  assign fire_s    = head_v_r & out_ready;
  assign out_fire  = fire_s;
  assign out_valid = head_v_r;
  assign out_data  = head_d_r;
  assign occupancy = {1'b0, pend_r} + {1'b0, head_v_r} + {1'b0, skid_v_r};
  // A slot freed by this cycle's transfer may be reused by a read issued in the same cycle.
  assign can_issue = (occupancy < 2'd2) || ((occupancy == 2'd2) && fire_s);

  // Next head/skid contents: returning data goes to the head whenever it is or becomes free.
  always_comb begin
    head_v_n = head_v_r;
    head_d_n = head_d_r;
    skid_v_n = skid_v_r;
    skid_d_n = skid_d_r;
    if (fire_s) begin
      if (skid_v_r) begin
        head_v_n = 1'b1;
        head_d_n = skid_d_r;
        if (pend_r) begin
          skid_v_n = 1'b1;
          skid_d_n = in_data;
        end else begin
          skid_v_n = 1'b0;
        end
      end else begin
        if (pend_r) begin
          head_v_n = 1'b1;
          head_d_n = in_data;
        end else begin
          head_v_n = 1'b0;
        end
      end
    end else begin
      if (pend_r) begin
        if (head_v_r) begin
          skid_v_n = 1'b1;
          skid_d_n = in_data;
        end else begin
          head_v_n = 1'b1;
          head_d_n = in_data;
        end
      end else begin
        head_v_n = head_v_r;
      end
    end
  end

  // Buffer and in-flight registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r   <= 1'b0;
      head_v_r <= 1'b0;
      head_d_r <= '0;
      skid_v_r <= 1'b0;
      skid_d_r <= '0;
    end else begin
      pend_r   <= issue;
      head_v_r <= head_v_n;
      head_d_r <= head_d_n;
      skid_v_r <= skid_v_n;
      skid_d_r <= skid_d_n;
    end
  end

endmodule

// File: rtl/bias_seq_ctrl.sv
// Bias ROM sequencer: streams NUM_CH biases NUM_PIX times into the accumulator FIFO.
// Define BIAS_SEQ_STALL_CNT_EN to add the 32-bit saturating stall_cnt output.
module bias_seq_ctrl
  import bias_seq_ctrl_pkg::*;
#(
  parameter int COEFF_W = COEFF_W_DEF,
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int NUM_PIX = NUM_PIX_DEF,
  parameter int ADDR_W  = addr_width(NUM_CH)
) (
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic               ap_start,
  output logic               ap_idle,
  output logic               ap_done,
  output logic [ADDR_W-1:0]  bias_V_address0,
  output logic               bias_V_ce0,
  input  logic [COEFF_W-1:0] bias_V_q0,
  output logic [COEFF_W-1:0] output_V_din,
  input  logic               output_V_full_n,
  output logic               output_V_write
`ifdef BIAS_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  localparam int PIX_W = addr_width(NUM_PIX);

  seq_state_e        state_r;
  seq_state_e        state_n;
  logic [ADDR_W-1:0] ch_r;
  logic [PIX_W-1:0]  pix_r;

  logic              issue_s;
  logic              can_issue_s;
  logic              fire_s;
  logic [1:0]        occ_s;
  logic              ch_last_s;
  logic              pix_last_s;
  logic              start_run_s;
  logic              drain_empty_s;

  assign ch_last_s     = (ch_r == ADDR_W'(NUM_CH - 1));
  assign pix_last_s    = (pix_r == PIX_W'(NUM_PIX - 1));
  assign start_run_s   = (state_r == ST_IDLE) && ap_start;
  assign issue_s       = (state_r == ST_RUN) && can_issue_s;
  // Empty once this cycle's transfer (if any) completes; no reads issue outside RUN.
  assign drain_empty_s = (occ_s == 2'd0) || ((occ_s == 2'd1) && fire_s);

  assign ap_idle         = (state_r == ST_IDLE);
  assign ap_done         = (state_r == ST_DONE);
  assign bias_V_ce0      = issue_s;
  assign bias_V_address0 = ch_r;

  bias_skid_buf #(
    .DATA_W (COEFF_W)
  ) u_buf (
    .clk       (ap_clk),
    .rst       (ap_rst),
    .issue     (issue_s),
    .in_data   (bias_V_q0),
    .out_ready (output_V_full_n),
    .out_valid (output_V_write),
    .out_data  (output_V_din),
    .out_fire  (fire_s),
    .occupancy (occ_s),
    .can_issue (can_issue_s)
  );

  // Next-state logic of the frame FSM.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: begin
        if (ap_start) begin
          state_n = ST_RUN;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (issue_s && ch_last_s && pix_last_s) begin
          state_n = ST_DRAIN;
        end else begin
          state_n = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_empty_s) begin
          state_n = ST_DONE;
        end else begin
          state_n = ST_DRAIN;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Channel/pixel counters advance on every issued read.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      ch_r  <= '0;
      pix_r <= '0;
    end else if (start_run_s) begin
      ch_r  <= '0;
      pix_r <= '0;
    end else if (issue_s) begin
      if (ch_last_s) begin
        ch_r  <= '0;
        pix_r <= pix_last_s ? '0 : (pix_r + PIX_W'(1));
      end else begin
        ch_r  <= ch_r + ADDR_W'(1);
      end
    end
  end

`ifdef BIAS_SEQ_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  assign stall_cnt = stall_cnt_r;

  // Cycles the FIFO refused a presented word, per frame, saturating.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      stall_cnt_r <= 32'd0;
    end else if (start_run_s) begin
      stall_cnt_r <= 32'd0;
    end else if (output_V_write && !output_V_full_n) begin
      stall_cnt_r <= sat_inc32(stall_cnt_r);
    end
  end
`endif

endmodule

// File: tb/tb_bias_seq_ctrl.sv
// Self-checking bench for bias_seq_ctrl: a 4ch x 3pix instance and a 1ch x 5pix instance.
// Define BIAS_SEQ_STALL_CNT_EN to also check the stall counter.
module tb_bias_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_a = 1'b0, idle_a, done_a, ce_a, full_n_a = 1'b1, write_a;
  logic [1:0]  addr_a;
  logic [15:0] q_a = 16'd0, din_a;
  logic        start_b = 1'b0, idle_b, done_b, ce_b, full_n_b = 1'b1, write_b;
  logic [0:0]  addr_b;
  logic [15:0] q_b = 16'd0, din_b;
`ifdef BIAS_SEQ_STALL_CNT_EN
  logic [31:0] stall_a, stall_b;
`endif

  logic [15:0] rom_a   [4]  = '{16'd10, 16'd20, 16'd30, 16'd40};
  logic [15:0] exp_seq [12] = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd10, 16'd20,
                                16'd30, 16'd40, 16'd10, 16'd20, 16'd30, 16'd40};

  // ROMs with one-cycle read latency
  always @(posedge clk) begin
    if (ce_a) q_a <= rom_a[addr_a];
    if (ce_b) q_b <= 16'd7;
  end

  bias_seq_ctrl #(.COEFF_W(16), .NUM_CH(4), .NUM_PIX(3)) dut_a (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start_a), .ap_idle(idle_a), .ap_done(done_a),
    .bias_V_address0(addr_a), .bias_V_ce0(ce_a), .bias_V_q0(q_a),
    .output_V_din(din_a), .output_V_full_n(full_n_a), .output_V_write(write_a)
`ifdef BIAS_SEQ_STALL_CNT_EN
    , .stall_cnt(stall_a)
`endif
  );

  bias_seq_ctrl #(.COEFF_W(16), .NUM_CH(1), .NUM_PIX(5)) dut_b (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start_b), .ap_idle(idle_b), .ap_done(done_b),
    .bias_V_address0(addr_b), .bias_V_ce0(ce_b), .bias_V_q0(q_b),
    .output_V_din(din_b), .output_V_full_n(full_n_b), .output_V_write(write_b)
`ifdef BIAS_SEQ_STALL_CNT_EN
    , .stall_cnt(stall_b)
`endif
  );

  int n_checks = 0, n_fail = 0, cyc_cnt = 0, first_x = 0, last_x = 0;
  int issued[2] = '{0, 0}, accepted[2] = '{0, 0}, done_cnt[2] = '{0, 0}, stall_model[2] = '{0, 0};
  bit done_exp[2] = '{1'b0, 1'b0}, prev_stall[2] = '{1'b0, 1'b0};
  int prev_din[2] = '{0, 0};
  logic [15:0] got_a[$], got_b[$];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int nch(input int id);
    return (id == 0) ? 4 : 1;
  endfunction

  function automatic int total(input int id);
    return (id == 0) ? 12 : 5;
  endfunction

  function automatic int rom_val(input int id, input int idx);
    return (id == 0) ? int'(rom_a[idx]) : 7;
  endfunction

  // Stream model: the k-th read must address channel k mod NUM_CH, the k-th accepted word is
  // rom[k mod NUM_CH], never more than 2 words outstanding, done exactly one cycle after the last word.
  task automatic check_cycle(input int id, input logic rst_v, input logic ce_v, input int addr_v,
                             input logic wr_v, input logic fn_v, input int din_v, input logic done_v);
    bit xfer;
    int occ;
    if (rst_v) begin
      issued[id] = 0; accepted[id] = 0; done_exp[id] = 1'b0; prev_stall[id] = 1'b0;
      return;
    end
    xfer = wr_v && fn_v;
    occ  = issued[id] - accepted[id];
    check("done", int'(done_v), int'(done_exp[id]));
    if (ce_v) begin
      check("ce_credit", int'((occ < 2) || (occ == 2 && xfer)), 1);
      check("addr", addr_v, issued[id] % nch(id));
      check("ce_bound", int'(issued[id] < total(id)), 1);
    end
    if (prev_stall[id]) begin
      check("hold_write", int'(wr_v), 1);
      check("hold_din", din_v, prev_din[id]);
    end
    if (xfer) begin
      check("din", din_v, rom_val(id, accepted[id] % nch(id)));
      if (id == 0) begin
        got_a.push_back(16'(din_v));
        if (accepted[id] == 0) first_x = cyc_cnt;
        last_x = cyc_cnt;
      end else begin
        got_b.push_back(16'(din_v));
      end
    end
    if (wr_v && !fn_v) stall_model[id]++;
    prev_stall[id] = wr_v && !fn_v;
    prev_din[id]   = din_v;
    issued[id]     = issued[id] + int'(ce_v);
    accepted[id]   = accepted[id] + int'(xfer);
    done_exp[id]   = xfer && (accepted[id] == total(id));
    if (done_v) begin
      done_cnt[id]++;
      issued[id] = 0;
      accepted[id] = 0;
    end
  endtask

  // Compare process, mid-cycle
  always @(negedge clk) begin
    cyc_cnt++;
    check_cycle(0, rst, ce_a, int'(addr_a), write_a, full_n_a, int'(din_a), done_a);
    check_cycle(1, rst, ce_b, int'(addr_b), write_b, full_n_b, int'(din_b), done_b);
  end

  function automatic logic fn_pat(input int mode, input int c);
    case (mode)
      1:       return (c % 4 == 0) || (c % 4 == 3);
      2:       return !(c >= 3 && c < 23);
      default: return 1'b1;
    endcase
  endfunction

  task automatic run_a(input int mode, input bit hold);
    int d0;
    bit seen;
    got_a.delete();
    d0 = done_cnt[0];
    stall_model[0] = 0;
    seen = 1'b0;
    start_a = 1'b1;
    full_n_a = fn_pat(mode, 0);
    for (int c = 1; c < 200 && !seen; c++) begin
      @(posedge clk); #1;
      if (!hold) start_a = 1'b0;
      full_n_a = fn_pat(mode, c);
      if (c == 2) check("pre_first_write", int'(write_a), 0);
      if (c == 3) begin
        check("first_write", int'(write_a), 1);
        check("first_din", int'(din_a), 10);
      end
      if (done_a) seen = 1'b1;
    end
    if (!seen) check("done_timeout", 0, 1);
    @(posedge clk); #1;
    start_a = 1'b0;
    full_n_a = 1'b1;
    check("idle_after", int'(idle_a), 1);
    check("done_pulses", done_cnt[0] - d0, 1);
    check("word_count", got_a.size(), 12);
    for (int i = 0; i < 12; i++)
      if (i < got_a.size()) check("seq", int'(got_a[i]), int'(exp_seq[i]));
`ifdef BIAS_SEQ_STALL_CNT_EN
    check("stall_cnt_a", int'(stall_a), stall_model[0]);
`endif
    if (hold) begin
      @(posedge clk); #1;
      check("start_in_done_ignored", int'(idle_a), 1);
    end
  endtask

  initial begin
    int d0, stalls;
    repeat (2) @(posedge clk);
    #1;
    check("rst_idle", int'(idle_a), 1);
    check("rst_done", int'(done_a), 0);
    check("rst_ce", int'(ce_a), 0);
    check("rst_write", int'(write_a), 0);
    check("rst_din", int'(din_a), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_a(0, 1'b0);
    check("throughput_span", last_x - first_x, 11);
    run_a(1, 1'b0);
    run_a(2, 1'b0);
`ifdef BIAS_SEQ_STALL_CNT_EN
    check("stall_cnt_20", int'(stall_a), 20);
`endif

    // Reset in the middle of a frame after five words
    got_a.delete();
    start_a = 1'b1;
    full_n_a = 1'b1;
    for (int c = 0; c < 100 && got_a.size() < 5; c++) begin
      @(posedge clk); #1;
      start_a = 1'b0;
    end
    check("pre_rst_words", got_a.size(), 5);
    rst = 1'b1;
    #1;
    check("mid_rst_idle", int'(idle_a), 1);
    check("mid_rst_ce", int'(ce_a), 0);
    check("mid_rst_addr", int'(addr_a), 0);
    check("mid_rst_write", int'(write_a), 0);
    check("mid_rst_din", int'(din_a), 0);
    check("mid_rst_done", int'(done_a), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_a(0, 1'b0);

    run_a(0, 1'b1);
    run_a(0, 1'b0);

    // NUM_CH=1 instance with three stall cycles
    got_b.delete();
    d0 = done_cnt[1];
    stall_model[1] = 0;
    stalls = 3;
    start_b = 1'b1;
    full_n_b = 1'b1;
    begin : run_b
      for (int c = 1; c < 200; c++) begin
        @(posedge clk); #1;
        start_b = 1'b0;
        if (write_b && stalls > 0) begin
          full_n_b = 1'b0;
          stalls--;
        end else begin
          full_n_b = 1'b1;
        end
        if (done_b) disable run_b;
      end
      check("done_timeout_b", 0, 1);
    end
    @(posedge clk); #1;
    full_n_b = 1'b1;
    check("idle_after_b", int'(idle_b), 1);
    check("done_pulses_b", done_cnt[1] - d0, 1);
    check("word_count_b", got_b.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < got_b.size()) check("seq_b", int'(got_b[i]), 7);
    check("stall_model_b", stall_model[1], 3);
`ifdef BIAS_SEQ_STALL_CNT_EN
    check("stall_cnt_b", int'(stall_b), 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
